// File: rtl/iob_pcie_pkg.sv
// Shared FSM encoding and beat geometry for the PCIe RX channel controller.
package iob_pcie_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_RECV = 2'd2,
      ST_DONE = 2'd3
   } rx_state_t;

   // One channel beat carries this many CPU words (C_PCI_DATA_WIDTH/DATA_W).
   localparam int BEAT_WORDS = 2;
   localparam int BEAT_SHIFT = $clog2(BEAT_WORDS);

endpackage

// File: rtl/iob_pcie_beat_cnt.sv
// Remaining-beat counter: loads ceil(len/BEAT_WORDS), decrements per accepted beat.
module iob_pcie_beat_cnt
   import iob_pcie_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] len_i,
   input  logic              dec_i,
   output logic              zero_o,
   output logic              last_o
);

   localparam int CNT_W = DATA_W + 1;

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] load_val_s;

   // One extra bit keeps the rounding add safe for an all-ones length.
   always_comb begin
      load_val_s = ({1'b0, len_i} + CNT_W'(BEAT_WORDS - 1)) >> BEAT_SHIFT;
      if (load_i) begin
         cnt_d = load_val_s;
      end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   iob_reg #(.DATA_W(CNT_W)) u_cnt_reg (
      .clk (clk),
      .rst (rst),
      .d_i (cnt_d),
      .q_o (cnt_q)
   );

   assign zero_o = (cnt_q == {CNT_W{1'b0}});
   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/iob_reg.sv
// Plain D register with synchronous active-high clear to zero.
module iob_reg #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_o <= {DATA_W{1'b0}};
      end else begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/iob_pcie_rx_ctrl.sv
// PCIe RX channel to FIFO bridge: handshake, beat counting, truncation detect.
// Optional statistics counters enabled with IOB_PCIE_RX_STAT_EN.
module iob_pcie_rx_ctrl
   import iob_pcie_pkg::*;
#(
   parameter int DATA_W           = 32,
   parameter int C_PCI_DATA_WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        PCIE_CHNL_RX_i,
   input  logic                        PCIE_CHNL_RX_LAST_i,
   input  logic [DATA_W-1:0]           PCIE_CHNL_RX_LEN_i,
   input  logic [C_PCI_DATA_WIDTH-1:0] PCIE_CHNL_RX_DATA_i,
   input  logic                        PCIE_CHNL_RX_DATA_VALID_i,
   output logic                        PCIE_CHNL_RX_DATA_REN_o,
   output logic                        PCIE_CHNL_RX_ACK_o,
   output logic [C_PCI_DATA_WIDTH-1:0] FIFO_W_DATA_o,
   output logic                        FIFO_W_EN_o,
   input  logic                        FIFO_W_FULL_i,
   output logic [DATA_W-1:0]           RX_LEN_o,
   output logic                        RX_LAST_o,
   output logic                        BUSY_o,
   output logic                        DONE_o,
   output logic                        ERR_o
`ifdef IOB_PCIE_RX_STAT_EN
   ,
   output logic [DATA_W-1:0]           RX_NTRANS_o,
   output logic [DATA_W-1:0]           RX_NERR_o
`endif
);

   rx_state_t         state_d;
   rx_state_t         state_q;
   logic [1:0]        state_bits_q;
   logic [DATA_W-1:0] rx_len_d;
   logic [DATA_W-1:0] rx_len_q;
   logic              rx_last_d;
   logic              rx_last_q;
   logic              err_d;
   logic              err_q;
   logic              done_d;
   logic              done_q;
   logic              ren_s;
   logic              accept_s;
   logic              cnt_load_s;
   logic              cnt_dec_s;
   logic              cnt_zero_s;
   logic              cnt_last_s;
   logic              err_set_s;

   assign state_q = rx_state_t'(state_bits_q);

   // Next-state and handshake decode.
   always_comb begin
      state_d    = state_q;
      rx_len_d   = rx_len_q;
      rx_last_d  = rx_last_q;
      err_d      = err_q;
      done_d     = 1'b0;
      ren_s      = 1'b0;
      accept_s   = 1'b0;
      cnt_load_s = 1'b0;
      cnt_dec_s  = 1'b0;
      err_set_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (PCIE_CHNL_RX_i) begin
               rx_len_d  = PCIE_CHNL_RX_LEN_i;
               rx_last_d = PCIE_CHNL_RX_LAST_i;
               err_d     = 1'b0;
               state_d   = ST_ACK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACK: begin
            cnt_load_s = 1'b1;
            if (rx_len_q == {DATA_W{1'b0}}) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_RECV;
            end
         end
         ST_RECV: begin
            ren_s    = ~FIFO_W_FULL_i;
            accept_s = ren_s & PCIE_CHNL_RX_DATA_VALID_i;
            // An accepted beat takes priority over a dropped request.
            if (accept_s) begin
               cnt_dec_s = 1'b1;
               if (cnt_last_s) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RECV;
               end
            end else if (!PCIE_CHNL_RX_i && !cnt_zero_s) begin
               err_d     = 1'b1;
               err_set_s = 1'b1;
               state_d   = ST_DONE;
               done_d    = 1'b1;
            end else begin
               state_d = ST_RECV;
            end
         end
         ST_DONE: begin
            if (!PCIE_CHNL_RX_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   iob_reg #(.DATA_W(2)) u_state_reg (
      .clk (clk),
      .rst (rst),
      .d_i (state_d),
      .q_o (state_bits_q)
   );

   iob_reg #(.DATA_W(DATA_W)) u_len_reg (
      .clk (clk),
      .rst (rst),
      .d_i (rx_len_d),
      .q_o (rx_len_q)
   );

   iob_reg #(.DATA_W(3)) u_flag_reg (
      .clk (clk),
      .rst (rst),
      .d_i ({rx_last_d, err_d, done_d}),
      .q_o ({rx_last_q, err_q, done_q})
   );

   iob_pcie_beat_cnt #(.DATA_W(DATA_W)) u_beat_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (cnt_load_s),
      .len_i  (rx_len_q),
      .dec_i  (cnt_dec_s),
      .zero_o (cnt_zero_s),
      .last_o (cnt_last_s)
   );

   assign PCIE_CHNL_RX_DATA_REN_o = ren_s;
   assign PCIE_CHNL_RX_ACK_o      = (state_q == ST_ACK);
   assign FIFO_W_EN_o             = accept_s;
   assign FIFO_W_DATA_o           = PCIE_CHNL_RX_DATA_i;
   assign RX_LEN_o                = rx_len_q;
   assign RX_LAST_o               = rx_last_q;
   assign BUSY_o                  = (state_q != ST_IDLE);
   assign DONE_o                  = done_q;
   assign ERR_o                   = err_q;

`ifdef IOB_PCIE_RX_STAT_EN
   logic [DATA_W-1:0] ntrans_d;
   logic [DATA_W-1:0] ntrans_q;
   logic [DATA_W-1:0] nerr_d;
   logic [DATA_W-1:0] nerr_q;

   // Free-running wrap-around event counters.
   always_comb begin
      ntrans_d = ntrans_q + DATA_W'(done_q);
      nerr_d   = nerr_q + DATA_W'(err_set_s);
   end

   iob_reg #(.DATA_W(DATA_W)) u_ntrans_reg (
      .clk (clk),
      .rst (rst),
      .d_i (ntrans_d),
      .q_o (ntrans_q)
   );

   iob_reg #(.DATA_W(DATA_W)) u_nerr_reg (
      .clk (clk),
      .rst (rst),
      .d_i (nerr_d),
      .q_o (nerr_q)
   );

   assign RX_NTRANS_o = ntrans_q;
   assign RX_NERR_o   = nerr_q;
`else
   logic unused_err_set_s;
   assign unused_err_set_s = err_set_s;
`endif

endmodule

// File: doc/iob_pcie_rx_ctrl.md
IOB_PCIE_RX_CTRL -- requirements
Module: iob_pcie_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, CPU/length word width.
REQ-002 SHALL have parameter C_PCI_DATA_WIDTH, default 64, channel data beat width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1 (sole clock, all logic on rising edge); rst input 1 (synchronous, active-high).
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
- PCIE_CHNL_RX_i input 1: transaction request.
- PCIE_CHNL_RX_LAST_i input 1: last transaction of sequence.
- PCIE_CHNL_RX_LEN_i input DATA_W: length in 32-bit words.
- PCIE_CHNL_RX_DATA_i input C_PCI_DATA_WIDTH: receive beat.
- PCIE_CHNL_RX_DATA_VALID_i input 1: beat valid.
- PCIE_CHNL_RX_DATA_REN_o output 1: beat consume.
- PCIE_CHNL_RX_ACK_o output 1: transaction acknowledge.
- FIFO_W_DATA_o output C_PCI_DATA_WIDTH: FIFO write data.
- FIFO_W_EN_o output 1: FIFO write strobe.
- FIFO_W_FULL_i input 1: downstream RX FIFO full.
- RX_LEN_o output DATA_W: latched transaction length.
- RX_LAST_o output 1: latched LAST flag.
- BUSY_o output 1: transaction in progress.
- DONE_o output 1: one-cycle completion pulse.
- ERR_o output 1: sticky truncation flag.

Function
REQ-005 SHALL implement FSM states IDLE, ACK, RECV, DONE.
REQ-006 IDLE: on PCIE_CHNL_RX_i=1 SHALL latch LEN into RX_LEN_o and LAST into RX_LAST_o, clear ERR_o, and go to ACK next cycle.
REQ-007 ACK: SHALL drive PCIE_CHNL_RX_ACK_o=1 for exactly one cycle and load the beat counter with ceil(LEN/2), computed in DATA_W+1 bits so LEN=0xFFFFFFFF does not overflow.
REQ-008 ACK exit: SHALL go to DONE if LEN=0, else to RECV.
REQ-009 RECV: PCIE_CHNL_RX_DATA_REN_o SHALL equal ~FIFO_W_FULL_i (combinational); in all other states REN SHALL be 0.
REQ-010 Beat accepted when REN_o & DATA_VALID_i: same cycle FIFO_W_EN_o=1, FIFO_W_DATA_o=PCIE_CHNL_RX_DATA_i (zero latency), and the beat counter decrements.
REQ-011 SHALL go to DONE in the cycle after the beat that brings the counter to 0; valid beats beyond the count SHALL NOT be consumed.
REQ-012 If FIFO_W_FULL_i=1, SHALL hold REN_o=0 and FIFO_W_EN_o=0 with counter unchanged; no beat is lost or duplicated.
REQ-013 If PCIE_CHNL_RX_i=0 in RECV with counter>0 and no beat accepted that cycle, SHALL set ERR_o=1 and go to DONE.
REQ-014 For odd LEN, the final beat SHALL be written whole; the upper 32 bits are don't-care.
REQ-015 DONE: SHALL pulse DONE_o for one cycle, then remain in DONE until PCIE_CHNL_RX_i=0, then go to IDLE; a held-high RX SHALL NOT start a second transaction.
REQ-016 BUSY_o SHALL be 1 in ACK, RECV and DONE, and 0 in IDLE.
REQ-017 FIFO_W_EN_o SHALL be 0 outside RECV.

Reset
REQ-018 On rst=1 at a clock edge, SHALL enter IDLE and clear the beat counter; ACK_o, REN_o, FIFO_W_EN_o, BUSY_o, DONE_o, ERR_o and RX_LAST_o SHALL be 0, and RX_LEN_o SHALL be 0.
REQ-019 Reset mid-transaction SHALL abort without a DONE_o pulse; the next transaction SHALL start only on PCIE_CHNL_RX_i=1 seen in IDLE.

Configuration
REQ-020 With IOB_PCIE_RX_STAT_EN defined, SHALL add outputs RX_NTRANS_o and RX_NERR_o (DATA_W each), incremented on each DONE_o pulse and each ERR_o set respectively, wrapping at 2^DATA_W and cleared by rst.
REQ-021 Without IOB_PCIE_RX_STAT_EN, these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-022 FSM state encodings and the beat-width constant (C_PCI_DATA_WIDTH/DATA_W = 2) SHALL live in shared package iob_pcie_pkg.
REQ-023 The beat counter with load/decrement/zero-detect SHALL be sub-module iob_pcie_beat_cnt; all state and output registers SHALL use iob_reg.

Verification
REQ-024 The bench SHALL cover: LEN=8, VALID always 1, FIFO never full -> ACK one cycle after RX, 4 writes on consecutive cycles, DONE_o pulse the next cycle, ERR_o=0.
REQ-025 The bench SHALL cover: LEN=5 -> exactly 3 writes, and a 4th valid beat is not consumed (REN_o=0).
REQ-026 The bench SHALL cover: LEN=8 with FIFO_W_FULL_i=1 for cycles 2-4 of RECV -> REN_o=0 during the stall, 4 writes total, data order preserved.
REQ-027 The bench SHALL cover: LEN=0 -> one ACK pulse, DONE_o, no FIFO writes.
REQ-028 The bench SHALL cover: LEN=8 with RX dropped after 2 beats -> ERR_o=1, DONE_o pulse, RX_NERR_o=1 when IOB_PCIE_RX_STAT_EN is defined.
REQ-029 The bench SHALL cover: rst asserted in RECV after 1 beat -> all outputs 0 next cycle, no DONE_o, and a new LEN=2 transaction completes normally.
